pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: PLL reset pulse, lock qualification, staged core/peripheral release.
// Optional WAIT_LOCK watchdog that re-resets the PLL is built when PLL_RST_SEQ_WDOG_EN is defined.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 8,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65535,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned LOSS_CNT_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  locked,
    output logic                  pll_resetb,
    output logic                  core_reset,
    output logic                  periph_reset,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic                  lock_timeout
);

    typedef enum logic [2:0] {
        PLLRST    = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_CORE  = 3'd3,
        RUN       = 3'd4
    } state_e;

    localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    // Every cycle count must be non-zero and representable in the shared counter.
    if (PLL_RST_CYCLES == 0 || STABLE_CYCLES == 0 || STAGE_GAP == 0 ||
        longint'(PLL_RST_CYCLES) > CNT_LIMIT || longint'(STABLE_CYCLES) > CNT_LIMIT ||
        longint'(STAGE_GAP) > CNT_LIMIT || longint'(LOCK_TIMEOUT) >= CNT_LIMIT) begin : g_bad_params
        $error("pll_reset_sequencer: cycle parameter out of range for CNT_W");
    end

    logic [1:0]            sync_q;
    logic                  lock_s;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lock_lost_q, lock_lost_d;
    logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;
    logic                  pll_resetb_q, core_reset_q, periph_reset_q, ready_q;
    logic                  loss;

    assign lock_s = sync_q[1];
    assign loss   = !lock_s && (state_q == REL_CORE || state_q == RUN);

`ifdef PLL_RST_SEQ_WDOG_EN
    logic lock_timeout_q, lock_timeout_d;
`endif

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        lock_lost_d  = lock_lost_q;
        loss_count_d = loss_count_q;
`ifdef PLL_RST_SEQ_WDOG_EN
        lock_timeout_d = lock_timeout_q;
`endif
        unique case (state_q)
            PLLRST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
`ifdef PLL_RST_SEQ_WDOG_EN
                else if (cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
                    state_d        = PLLRST;
                    cnt_d          = '0;
                    lock_timeout_d = 1'b1;
                end
`else
                else begin
                    cnt_d = '0;
                end
`endif
            end
            STABLE: begin
                // A lock drop before release only restarts qualification; it is not a loss.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = REL_CORE;
                    cnt_d   = '0;
                end
            end
            REL_CORE: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = PLLRST;
                cnt_d   = '0;
            end
        endcase

        // Overrides the REL_CORE->RUN step when both fall on the same cycle.
        if (loss) begin
            state_d     = WAIT_LOCK;
            cnt_d       = '0;
            lock_lost_d = 1'b1;
            if (loss_count_q != '1) begin
                loss_count_d = loss_count_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q         <= '0;
            state_q        <= PLLRST;
            cnt_q          <= '0;
            lock_lost_q    <= 1'b0;
            loss_count_q   <= '0;
            pll_resetb_q   <= 1'b0;
            core_reset_q   <= 1'b1;
            periph_reset_q <= 1'b1;
            ready_q        <= 1'b0;
        end else begin
            sync_q         <= {sync_q[0], locked};
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lock_lost_q    <= lock_lost_d;
            loss_count_q   <= loss_count_d;
            // Outputs are decoded from the next state so they change together with it.
            pll_resetb_q   <= (state_d != PLLRST);
            core_reset_q   <= !(state_d == REL_CORE || state_d == RUN);
            periph_reset_q <= (state_d != RUN);
            ready_q        <= (state_d == RUN);
        end
    end

`ifdef PLL_RST_SEQ_WDOG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_timeout_q <= 1'b0;
        end else begin
            lock_timeout_q <= lock_timeout_d;
        end
    end
    assign lock_timeout = lock_timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

    assign pll_resetb   = pll_resetb_q;
    assign core_reset   = core_reset_q;
    assign periph_reset = periph_reset_q;
    assign ready        = ready_q;
    assign lock_lost    = lock_lost_q;
    assign loss_count   = loss_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: release timing, lock drops, loss saturation, mid-sequence reset, watchdog.
// Cycle 0 is the cycle in which reset is deasserted; values are sampled 1 ns after each rising edge.
module tb_pll_reset_sequencer;

    localparam int unsigned LOSS_CNT_W = 8;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  locked = 1'b0;
    logic                  pll_resetb;
    logic                  core_reset;
    logic                  periph_reset;
    logic                  ready;
    logic                  lock_lost;
    logic [LOSS_CNT_W-1:0] loss_count;
    logic                  lock_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_loss;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (8),
        .STABLE_CYCLES  (16),
        .STAGE_GAP      (4),
        .LOCK_TIMEOUT   (100),
        .CNT_W          (16),
        .LOSS_CNT_W     (LOSS_CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .locked       (locked),
        .pll_resetb   (pll_resetb),
        .core_reset   (core_reset),
        .periph_reset (periph_reset),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .loss_count   (loss_count),
        .lock_timeout (lock_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_resetb"}, pll_resetb, 0);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_periph_reset"}, periph_reset, 1);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_lock_lost"}, lock_lost, 0);
        check({tag, "_loss_count"}, loss_count, 0);
        check({tag, "_lock_timeout"}, lock_timeout, 0);
    endtask

    task automatic wait_core_release(input string tag);
        int n = 0;
        while (core_reset !== 1'b0 && n < 64) begin
            step();
            n++;
        end
        check(tag, core_reset, 0);
    endtask

    initial begin
        // 1: power-up sequence, locked rises at cycle 20
        do_reset();
        check_reset_values("t1_rst");
        step_to(7);  check("t1_pll_resetb_c7", pll_resetb, 0);
        step_to(8);  check("t1_pll_resetb_c8", pll_resetb, 1);
        step_to(20); locked = 1'b1;
        step_to(38); check("t1_core_c38", core_reset, 1);
        step_to(39); check("t1_core_c39", core_reset, 0);
                     check("t1_periph_c39", periph_reset, 1);
        step_to(42); check("t1_ready_c42", ready, 0);
        step_to(43); check("t1_periph_c43", periph_reset, 0);
                     check("t1_ready_c43", ready, 1);

        // 2: locked held from reset, dropped for cycles 12-13 while in STABLE
        do_reset();
        step_to(12); locked = 1'b0;
        step_to(14); locked = 1'b1;
        step_to(25); check("t2_core_c25", core_reset, 1);
        step_to(32); check("t2_core_c32", core_reset, 1);
                     check("t2_lock_lost", lock_lost, 0);
        step_to(33); check("t2_core_c33", core_reset, 0);
                     check("t2_loss_count", loss_count, 0);

        // 3: lock loss in RUN at cycle 40, relock at 45 without a PLL reset
        step_to(37); check("t3_ready_c37", ready, 1);
        step_to(40); locked = 1'b0;
        step_to(42); check("t3_ready_c42", ready, 1);
        step_to(43); check("t3_core_c43", core_reset, 1);
                     check("t3_periph_c43", periph_reset, 1);
                     check("t3_ready_c43", ready, 0);
                     check("t3_lock_lost", lock_lost, 1);
                     check("t3_loss_count", loss_count, 1);
                     check("t3_pll_resetb_c43", pll_resetb, 1);
        step_to(45); locked = 1'b1;
        step_to(50); check("t3_pll_resetb_c50", pll_resetb, 1);
        step_to(63); check("t3_core_c63", core_reset, 1);
        step_to(64); check("t3_core_c64", core_reset, 0);
        step_to(67); check("t3_ready_c67", ready, 0);
        step_to(68); check("t3_ready_c68", ready, 1);
                     check("t3_periph_c68", periph_reset, 0);

        // 4: 299 further losses (300 total); each hits REL_CORE on its last cycle so loss beats RUN
        exp_loss = 1;
        for (int i = 0; i < 299; i++) begin
            step();
            locked = 1'b0;
            repeat (3) step();
            check("t4_ready_after_loss", ready, 0);
            check("t4_core_after_loss", core_reset, 1);
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            check("t4_loss_count", loss_count, exp_loss);
            locked = 1'b1;
            wait_core_release("t4_relock");
        end
        check("t4_loss_count_final", loss_count, 255);
        check("t4_lock_lost_final", lock_lost, 1);

        // 5: reset pulsed while in REL_CORE (locked stays high)
        check("t5_in_rel_core_ready", ready, 0);
        reset = 1'b1;
        step();
        check_reset_values("t5_rst");
        reset = 1'b0;
        cyc = 0;
        step_to(7);  check("t5_pll_resetb_c7", pll_resetb, 0);
        step_to(8);  check("t5_pll_resetb_c8", pll_resetb, 1);
        step_to(24); check("t5_core_c24", core_reset, 1);
        step_to(25); check("t5_core_c25", core_reset, 0);

        // 6: locked held low; watchdog re-resets the PLL every 109 cycles when built
        locked = 1'b0;
        do_reset();
        step_to(108); check("t6_pll_resetb_c108", pll_resetb, 1);
                      check("t6_timeout_c108", lock_timeout, 0);
`ifdef PLL_RST_SEQ_WDOG_EN
        step_to(109); check("t6_pll_resetb_c109", pll_resetb, 0);
                      check("t6_timeout_c109", lock_timeout, 1);
        step_to(116); check("t6_pll_resetb_c116", pll_resetb, 0);
        step_to(117); check("t6_pll_resetb_c117", pll_resetb, 1);
        step_to(217); check("t6_pll_resetb_c217", pll_resetb, 1);
        step_to(218); check("t6_pll_resetb_c218", pll_resetb, 0);
                      check("t6_timeout_c218", lock_timeout, 1);
`else
        step_to(109); check("t6_pll_resetb_c109", pll_resetb, 1);
                      check("t6_timeout_c109", lock_timeout, 0);
        step_to(218); check("t6_pll_resetb_c218", pll_resetb, 1);
                      check("t6_timeout_c218", lock_timeout, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
